// File: rtl/pipe_ctrl_pkg.sv
// rtl/pipe_ctrl_pkg.sv - shared constants and types for the pipeline controller
//
// Purpose: stall vector encodings, controller state encoding and the
// stall-request priority merge used by pipe_ctrl.
// Ports: none (package).
package pipe_ctrl_pkg;

  localparam logic Stop   = 1'b1;
  localparam logic NoStop = 1'b0;

  // Bit order: [0]PC [1]IF [2]ID [3]EX [4]MEM [5]WB. A stage stall also
  // freezes every stage upstream of it, while WB keeps draining.
  localparam logic [5:0] StallNone    = 6'b000000;
  localparam logic [5:0] StallFromIF  = 6'b000011;
  localparam logic [5:0] StallFromID  = 6'b000111;
  localparam logic [5:0] StallFromEX  = 6'b001111;
  localparam logic [5:0] StallFromMEM = 6'b011111;
  localparam logic [5:0] StallWaitIF  = 6'b000011;

  typedef enum logic {
    CtrlRun    = 1'b0,
    CtrlWaitIF = 1'b1
  } ctrl_state_e;

  // The most downstream requester wins, because its stall pattern already
  // covers every upstream stage.
  function automatic logic [5:0] stall_merge(input logic req_if, input logic req_id,
                                             input logic req_ex, input logic req_mem);
    logic [5:0] v;
    if (req_mem)     v = StallFromMEM;
    else if (req_ex) v = StallFromEX;
    else if (req_id) v = StallFromID;
    else if (req_if) v = StallFromIF;
    else             v = StallNone;
    return v;
  endfunction

endpackage

// File: rtl/pipe_ctrl_sat_counter.sv
// rtl/pipe_ctrl_sat_counter.sv - saturating event counter
//
// Purpose: counts cycles with en=1, sticking at all-ones instead of wrapping.
// Ports:
//   clk   in  clock
//   rst   in  asynchronous reset, active-low
//   en    in  count this cycle
//   count out current count
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  output logic [W-1:0] count
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (en && (cnt_q != {W{1'b1}})) begin
      cnt_d = cnt_q + {{(W-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign count = cnt_q;

endmodule

// File: rtl/pipe_ctrl.sv
// rtl/pipe_ctrl.sv - pipeline stall/flush/redirect controller
//
// Purpose: merges stage stall requests into the stall vector, turns EX
// mispredicts and MEM exceptions into a flush pulse plus PC redirect, parks
// the redirect while an un-abortable fetch is outstanding, and counts stall
// cycles and flush pulses.
// Ports:
//   clk, rst                 clock, asynchronous active-low reset
//   stallreq_if/id/ex/mem    per-stage stall requests
//   ex_mispredict, ex_redirect_pc   branch mispredict and correct target
//   mem_excp, mem_excp_vec   exception and handler address
//   if_busy                  fetch outstanding, cannot be aborted
//   stall[5:0]               per-stage hold, 1 = Stop
//   flush                    kill if_id/id_ex/ex_mem on next edge
//   pc_load, new_pc          PC redirect
//   if_discard               drop the fetch data returning this cycle
//   stall_cnt, flush_cnt     saturating performance counters
module pipe_ctrl #(
  parameter int CNT_W     = 32,
  parameter int InstAddrW = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 stallreq_if,
  input  logic                 stallreq_id,
  input  logic                 stallreq_ex,
  input  logic                 stallreq_mem,
  input  logic                 ex_mispredict,
  input  logic [InstAddrW-1:0] ex_redirect_pc,
  input  logic                 mem_excp,
  input  logic [InstAddrW-1:0] mem_excp_vec,
  input  logic                 if_busy,
  output logic [5:0]           stall,
  output logic                 flush,
  output logic                 pc_load,
  output logic [InstAddrW-1:0] new_pc,
  output logic                 if_discard,
  output logic [CNT_W-1:0]     stall_cnt,
  output logic [CNT_W-1:0]     flush_cnt
);

  import pipe_ctrl_pkg::*;

  ctrl_state_e          state_q, state_d;
  logic [InstAddrW-1:0] saved_q, saved_d;
  logic [InstAddrW-1:0] last_pc_q, last_pc_d;

  logic                 run_evt;
  logic [InstAddrW-1:0] run_target;
  logic [InstAddrW-1:0] wait_target;

  // A mispredict seen while MEM is stalled is left alone: EX is frozen, so it
  // is presented again once the MEM stall clears.
  assign run_evt    = mem_excp | (ex_mispredict & ~stallreq_mem);
  assign run_target = mem_excp ? mem_excp_vec : ex_redirect_pc;
  // While parked, a new exception replaces the pending redirect target.
  assign wait_target = mem_excp ? mem_excp_vec : saved_q;

  always_comb begin
    state_d    = state_q;
    saved_d    = saved_q;
    last_pc_d  = last_pc_q;
    stall      = StallNone;
    flush      = 1'b0;
    pc_load    = 1'b0;
    if_discard = 1'b0;
    new_pc     = last_pc_q;

    case (state_q)
      CtrlRun: begin
        if (run_evt) begin
          // Younger instructions are being killed, so their stall
          // requests are irrelevant this cycle.
          flush = 1'b1;
          if (!if_busy) begin
            pc_load = 1'b1;
            new_pc  = run_target;
          end else begin
            saved_d = run_target;
            state_d = CtrlWaitIF;
          end
        end else begin
          stall = stall_merge(stallreq_if, stallreq_id, stallreq_ex, stallreq_mem);
        end
      end
      CtrlWaitIF: begin
        // Hold PC/IF until the in-flight fetch returns; bubbles drain below.
        stall   = StallWaitIF;
        flush   = mem_excp;
        saved_d = wait_target;
        if (!if_busy) begin
          pc_load    = 1'b1;
          new_pc     = wait_target;
          if_discard = 1'b1;
          state_d    = CtrlRun;
        end
      end
      default: begin
        state_d = CtrlRun;
      end
    endcase

    if (pc_load) begin
      last_pc_d = new_pc;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= CtrlRun;
      saved_q   <= '0;
      last_pc_q <= '0;
    end else begin
      state_q   <= state_d;
      saved_q   <= saved_d;
      last_pc_q <= last_pc_d;
    end
  end

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .en    (stall != StallNone),
    .count (stall_cnt)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst   (rst),
    .en    (flush),
    .count (flush_cnt)
  );

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb/tb_pipe_ctrl.sv - self-checking bench for pipe_ctrl
module tb_pipe_ctrl;

  localparam int CW   = 4;
  localparam int AW   = 32;
  localparam int MAXC = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          stallreq_if = 1'b0, stallreq_id = 1'b0, stallreq_ex = 1'b0, stallreq_mem = 1'b0;
  logic          ex_mispredict = 1'b0;
  logic [AW-1:0] ex_redirect_pc = '0;
  logic          mem_excp = 1'b0;
  logic [AW-1:0] mem_excp_vec = '0;
  logic          if_busy = 1'b0;
  logic [5:0]    stall;
  logic          flush, pc_load, if_discard;
  logic [AW-1:0] new_pc;
  logic [CW-1:0] stall_cnt, flush_cnt;

  pipe_ctrl #(.CNT_W(CW), .InstAddrW(AW)) dut (
    .clk(clk), .rst(rst),
    .stallreq_if(stallreq_if), .stallreq_id(stallreq_id),
    .stallreq_ex(stallreq_ex), .stallreq_mem(stallreq_mem),
    .ex_mispredict(ex_mispredict), .ex_redirect_pc(ex_redirect_pc),
    .mem_excp(mem_excp), .mem_excp_vec(mem_excp_vec), .if_busy(if_busy),
    .stall(stall), .flush(flush), .pc_load(pc_load), .new_pc(new_pc),
    .if_discard(if_discard), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: pending-redirect flag, parked target, last redirect
  // target and event counts.
  bit            m_on = 1'b0;
  bit            m_wait;
  logic [AW-1:0] m_saved, m_last;
  int            m_scnt, m_fcnt;

  always @(negedge clk) begin
    if (m_on) begin
      if (!rst) begin
        check("rst_stall", {26'd0, stall}, 32'd0);
        check("rst_flush", {31'd0, flush}, 32'd0);
        check("rst_pc_load", {31'd0, pc_load}, 32'd0);
        check("rst_new_pc", new_pc, 32'd0);
        check("rst_if_discard", {31'd0, if_discard}, 32'd0);
        check("rst_stall_cnt", {28'd0, stall_cnt}, 32'd0);
        check("rst_flush_cnt", {28'd0, flush_cnt}, 32'd0);
        m_wait  = 1'b0;
        m_saved = '0;
        m_last  = '0;
        m_scnt  = 0;
        m_fcnt  = 0;
      end else begin
        logic [5:0]    es;
        bit            ef, el, ed;
        logic [AW-1:0] ep, tgt;
        int            top;
        es = 6'd0; ef = 1'b0; el = 1'b0; ed = 1'b0; ep = '0;
        if (!m_wait) begin
          if (mem_excp || (ex_mispredict && !stallreq_mem)) begin
            ef  = 1'b1;
            tgt = mem_excp ? mem_excp_vec : ex_redirect_pc;
            if (if_busy) begin
              m_wait  = 1'b1;
              m_saved = tgt;
            end else begin
              el = 1'b1;
              ep = tgt;
            end
          end else begin
            // Stalling stage k (IF=1..MEM=4) holds bits [k:0].
            top = stallreq_mem ? 5 : stallreq_ex ? 4 : stallreq_id ? 3 : stallreq_if ? 2 : 0;
            es  = 6'((1 << top) - 1);
          end
        end else begin
          es = 6'b000011;
          if (mem_excp) begin
            ef      = 1'b1;
            m_saved = mem_excp_vec;
          end
          if (!if_busy) begin
            el     = 1'b1;
            ep     = m_saved;
            ed     = 1'b1;
            m_wait = 1'b0;
          end
        end
        if (el) m_last = ep;
        check("stall", {26'd0, stall}, {26'd0, es});
        check("flush", {31'd0, flush}, {31'd0, ef});
        check("pc_load", {31'd0, pc_load}, {31'd0, el});
        check("new_pc", new_pc, m_last);
        check("if_discard", {31'd0, if_discard}, {31'd0, ed});
        check("stall_cnt", {28'd0, stall_cnt}, 32'(m_scnt));
        check("flush_cnt", {28'd0, flush_cnt}, 32'(m_fcnt));
        if (es != 6'd0 && m_scnt < MAXC) m_scnt++;
        if (ef && m_fcnt < MAXC) m_fcnt++;
      end
    end
  end

  // sreq = {mem, ex, id, if}
  task automatic apply(input logic [3:0] sreq, input logic mis, input logic [31:0] rpc,
                       input logic exc, input logic [31:0] vec, input logic busy);
    @(posedge clk);
    #1;
    {stallreq_mem, stallreq_ex, stallreq_id, stallreq_if} = sreq;
    ex_mispredict  = mis;
    ex_redirect_pc = rpc;
    mem_excp       = exc;
    mem_excp_vec   = vec;
    if_busy        = busy;
    @(negedge clk);
  endtask

  task automatic idle();
    apply(4'b0000, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
  endtask

  initial begin
    #1 rst = 1'b0;
    m_on = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    check("lit_reset_stall", {26'd0, stall}, 32'd0);
    check("lit_reset_cnt", {28'd0, stall_cnt}, 32'd0);

    // EX and ID together: EX pattern wins
    repeat (3) begin
      apply(4'b0110, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
      check("lit_ex_id_stall", {26'd0, stall}, 32'h0f);
    end
    idle();
    check("lit_stall_cnt3", {28'd0, stall_cnt}, 32'd3);

    // single-source priorities and all-at-once
    apply(4'b0001, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    apply(4'b0010, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    apply(4'b0100, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    apply(4'b1000, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    apply(4'b1111, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    check("lit_all_stall", {26'd0, stall}, 32'h1f);
    idle();

    // plain mispredict, flush wins over ID/EX stall requests
    apply(4'b0110, 1'b1, 32'h80, 1'b0, 32'h0, 1'b0);
    check("lit_mis_flush", {31'd0, flush}, 32'd1);
    check("lit_mis_load", {31'd0, pc_load}, 32'd1);
    check("lit_mis_pc", new_pc, 32'h80);
    check("lit_mis_stall", {26'd0, stall}, 32'd0);
    idle();
    check("lit_mis_flush_off", {31'd0, flush}, 32'd0);
    check("lit_flush_cnt1", {28'd0, flush_cnt}, 32'd1);
    check("lit_pc_hold", new_pc, 32'h80);

    // exception beats mispredict
    apply(4'b0000, 1'b1, 32'h80, 1'b1, 32'h100, 1'b0);
    check("lit_excp_pc", new_pc, 32'h100);
    idle();
    check("lit_flush_cnt2", {28'd0, flush_cnt}, 32'd2);

    // mispredict deferred by MEM stall
    repeat (3) begin
      apply(4'b1000, 1'b1, 32'hc0, 1'b0, 32'h0, 1'b0);
      check("lit_defer_stall", {26'd0, stall}, 32'h1f);
      check("lit_defer_noflush", {31'd0, flush}, 32'd0);
    end
    apply(4'b0000, 1'b1, 32'hc0, 1'b0, 32'h0, 1'b0);
    check("lit_defer_flush", {31'd0, flush}, 32'd1);
    check("lit_defer_pc", new_pc, 32'hc0);

    // redirect parked behind busy fetch
    apply(4'b0000, 1'b1, 32'h40, 1'b0, 32'h0, 1'b1);
    check("lit_park_flush", {31'd0, flush}, 32'd1);
    check("lit_park_noload", {31'd0, pc_load}, 32'd0);
    apply(4'b0100, 1'b1, 32'h99, 1'b0, 32'h0, 1'b1);
    check("lit_wait_stall", {26'd0, stall}, 32'h03);
    apply(4'b0000, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    check("lit_wait_load", {31'd0, pc_load}, 32'd1);
    check("lit_wait_pc", new_pc, 32'h40);
    check("lit_wait_discard", {31'd0, if_discard}, 32'd1);
    idle();
    check("lit_back_run", {26'd0, stall}, 32'd0);

    // exception while parked replaces the target
    apply(4'b0000, 1'b1, 32'h200, 1'b0, 32'h0, 1'b1);
    apply(4'b0000, 1'b0, 32'h0, 1'b1, 32'h300, 1'b1);
    check("lit_wexc_flush", {31'd0, flush}, 32'd1);
    apply(4'b0000, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    check("lit_wexc_pc", new_pc, 32'h300);
    // exception on the exit cycle itself
    apply(4'b0000, 1'b1, 32'h400, 1'b0, 32'h0, 1'b1);
    apply(4'b0000, 1'b0, 32'h0, 1'b1, 32'h440, 1'b0);
    idle();

    // asynchronous reset in the middle of WAIT_IF
    apply(4'b0000, 1'b1, 32'h500, 1'b0, 32'h0, 1'b1);
    apply(4'b0000, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
    @(posedge clk);
    #1 rst = 1'b0;
    #1;
    check("lit_arst_stall", {26'd0, stall}, 32'd0);
    check("lit_arst_pc", new_pc, 32'd0);
    check("lit_arst_cnt", {28'd0, flush_cnt}, 32'd0);
    @(negedge clk);
    @(posedge clk);
    #1;
    rst = 1'b1;
    if_busy = 1'b0;
    @(negedge clk);
    check("lit_arst_noload", {31'd0, pc_load}, 32'd0);
    idle();
    check("lit_arst_noload2", {31'd0, pc_load}, 32'd0);

    // counter saturation
    repeat (20) apply(4'b0001, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    check("lit_stall_sat", {28'd0, stall_cnt}, 32'(MAXC));
    repeat (18) apply(4'b0000, 1'b1, 32'h600, 1'b0, 32'h0, 1'b0);
    check("lit_flush_sat", {28'd0, flush_cnt}, 32'(MAXC));
    idle();
    idle();

    m_on = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
